// File: rtl/zuse_ctrl_pkg.sv
// rtl/zuse_ctrl_pkg.sv - shared opcodes, state codes, status layout and byte-count helper
package zuse_ctrl_pkg;

    localparam logic [3:0] OPC_STATUS  = 4'h0;
    localparam logic [3:0] OPC_WRITE   = 4'h1;
    localparam logic [3:0] OPC_READ    = 4'h2;
    localparam logic [3:0] OPC_READRES = 4'h3;
    localparam logic [3:0] OPC_ADD     = 4'h4;
    localparam logic [3:0] OPC_SUB     = 4'h5;
    localparam logic [3:0] OPC_MUL     = 4'h6;

    localparam logic [3:0] ST_IDLE         = 4'd0;
    localparam logic [3:0] ST_STAT_TX      = 4'd1;
    localparam logic [3:0] ST_WRITE_RX     = 4'd2;
    localparam logic [3:0] ST_WRITE_COMMIT = 4'd3;
    localparam logic [3:0] ST_READ_TX      = 4'd4;
    localparam logic [3:0] ST_TX_GAP       = 4'd5;
    localparam logic [3:0] ST_OP_START     = 4'd6;
    localparam logic [3:0] ST_OP_GUARD     = 4'd7;
    localparam logic [3:0] ST_OP_WAIT      = 4'd8;
    localparam logic [3:0] ST_OP_WB        = 4'd9;

    localparam logic [1:0] SER_IDLE  = 2'd0;
    localparam logic [1:0] SER_WAIT  = 2'd1;
    localparam logic [1:0] SER_PULSE = 2'd2;
    localparam logic [1:0] SER_GAP   = 2'd3;

    localparam int STAT_ERR_BIT   = 7;
    localparam int STAT_TO_BIT    = 6;
    localparam int STAT_BUSY_BIT  = 3;
    localparam int STAT_FLAGS_LSB = 0;

    function automatic int nbytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/zuse_word_serializer.sv
// rtl/zuse_word_serializer.sv - left-aligned MSB-first byte serializer with tx_busy handshake
module zuse_word_serializer
    import zuse_ctrl_pkg::*;
#(
    parameter int W = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_word,
    input  logic [W-1:0] word,
    input  logic         load_byte,
    input  logic [7:0]   byte_data,
    input  logic         tx_busy,
    output logic         tx_en,
    output logic [7:0]   tx_data,
    output logic         done
);

    localparam int NB = nbytes(W);
    localparam int BW = NB * 8;
    localparam int CW = $clog2(NB + 1);

    logic [1:0]    phase;
    logic [BW-1:0] sh;
    logic [CW-1:0] remaining;
    logic [BW-1:0] word_ext;
    logic [BW-1:0] byte_ext;

    assign word_ext = BW'(word) << (BW - W);
    assign byte_ext = BW'(byte_data) << (BW - 8);
    assign done     = (phase == SER_WAIT) && (remaining == '0) && !tx_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= SER_IDLE;
            sh        <= '0;
            remaining <= '0;
            tx_en     <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            case (phase)
                SER_IDLE: begin
                    tx_en <= 1'b0;
                    if (load_word) begin
                        sh        <= word_ext;
                        remaining <= CW'(NB);
                        phase     <= SER_WAIT;
                    end else if (load_byte) begin
                        sh        <= byte_ext;
                        remaining <= CW'(1);
                        phase     <= SER_WAIT;
                    end
                end
                // Both the next byte and completion wait for the transmitter to go idle.
                SER_WAIT: begin
                    if (!tx_busy) begin
                        if (remaining == '0) begin
                            phase <= SER_IDLE;
                        end else begin
                            tx_en     <= 1'b1;
                            tx_data   <= sh[BW-1 -: 8];
                            sh        <= sh << 8;
                            remaining <= remaining - 1'b1;
                            phase     <= SER_PULSE;
                        end
                    end
                end
                SER_PULSE: begin
                    tx_en <= 1'b0;
                    phase <= SER_GAP;
                end
                default: phase <= SER_WAIT;
            endcase
        end
    end

endmodule

// File: rtl/zuse_uart_ctrl_n.sv
// rtl/zuse_uart_ctrl_n.sv - UART command controller for NREGS FPU operand registers
// Optional result write-back into regs[rA] under ZUSE_CTRL_WRITEBACK_EN.
module zuse_uart_ctrl_n
    import zuse_ctrl_pkg::*;
#(
    parameter int EXP_W       = 7,
    parameter int MAN_W       = 15,
    parameter int NREGS       = 4,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               tx_busy,
    output logic               tx_en,
    output logic [7:0]         tx_data,
    output logic [EXP_W+MAN_W:0] op_a,
    output logic [EXP_W+MAN_W:0] op_b,
    output logic               fpu_add,
    output logic               fpu_sub,
    output logic               fpu_mul,
    input  logic [EXP_W+MAN_W:0] fpu_res,
    input  logic [2:0]         fpu_flags,
    input  logic               fpu_idle
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int NB = nbytes(W);
    localparam int BW = NB * 8;
    localparam logic [2:0]  NREGS_L   = 3'(NREGS);
    localparam logic [3:0]  LAST_BYTE = 4'(NB - 1);
    localparam bit          TO_EN     = (TIMEOUT_CYC > 0);
    localparam logic [31:0] TO_LAST   = TO_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;
`ifdef ZUSE_CTRL_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic [3:0]    state;
    logic [W-1:0]  regs [4];
    logic [BW-1:0] shadow;
    logic [3:0]    byte_cnt;
    logic [31:0]   to_cnt;
    logic [1:0]    cur_ra;
    logic          err_sticky;
    logic          to_sticky;

    logic [3:0]    opc;
    logic [1:0]    ra;
    logic [1:0]    rb;
    logic          ra_ok;
    logic          rb_ok;
    logic          accept;
    logic          cmd_err;
    logic          timeout_evt;
    logic          ser_load_word;
    logic          ser_load_byte;
    logic [W-1:0]  ser_word;
    logic [7:0]    status_byte;
    logic          ser_done;
    logic          unused_pad;

    assign opc    = rx_data[7:4];
    assign ra     = rx_data[3:2];
    assign rb     = rx_data[1:0];
    assign ra_ok  = {1'b0, ra} < NREGS_L;
    assign rb_ok  = {1'b0, rb} < NREGS_L;
    assign accept = (state == ST_IDLE) && rx_valid;
    assign timeout_evt = TO_EN && (state == ST_WRITE_RX) && !rx_valid && (to_cnt == TO_LAST);
    // Padding bits of the final payload byte are don't-care.
    assign unused_pad = ^shadow;

    always_comb begin
        cmd_err       = 1'b0;
        ser_load_word = 1'b0;
        ser_load_byte = 1'b0;
        ser_word      = regs[ra];
        if (accept) begin
            case (opc)
                OPC_STATUS:  ser_load_byte = 1'b1;
                OPC_WRITE:   cmd_err = !ra_ok;
                OPC_READ: begin
                    cmd_err       = !ra_ok;
                    ser_load_word = ra_ok;
                end
                OPC_READRES: begin
                    ser_load_word = 1'b1;
                    ser_word      = fpu_res;
                end
                OPC_ADD, OPC_SUB, OPC_MUL: cmd_err = !(ra_ok && rb_ok);
                default:     cmd_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        status_byte = 8'h00;
        status_byte[STAT_ERR_BIT]  = err_sticky;
        status_byte[STAT_TO_BIT]   = to_sticky;
        status_byte[STAT_BUSY_BIT] = ~fpu_idle;
        status_byte[STAT_FLAGS_LSB +: 3] = fpu_flags;
    end

    zuse_word_serializer #(.W(W)) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load_word (ser_load_word),
        .word      (ser_word),
        .load_byte (ser_load_byte),
        .byte_data (status_byte),
        .tx_busy   (tx_busy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .done      (ser_done)
    );

    // A new sticky event outranks the clear caused by the STATUS byte going out.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
            to_sticky  <= 1'b0;
        end else begin
            if (state == ST_STAT_TX && tx_en) begin
                err_sticky <= 1'b0;
                to_sticky  <= 1'b0;
            end
            if (cmd_err)     err_sticky <= 1'b1;
            if (timeout_evt) to_sticky  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            shadow   <= '0;
            byte_cnt <= 4'd0;
            to_cnt   <= 32'd0;
            cur_ra   <= 2'd0;
            op_a     <= '0;
            op_b     <= '0;
            fpu_add  <= 1'b0;
            fpu_sub  <= 1'b0;
            fpu_mul  <= 1'b0;
        end else begin
            fpu_add <= 1'b0;
            fpu_sub <= 1'b0;
            fpu_mul <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && !cmd_err) begin
                        case (opc)
                            OPC_STATUS: state <= ST_STAT_TX;
                            OPC_WRITE: begin
                                cur_ra   <= ra;
                                byte_cnt <= 4'd0;
                                to_cnt   <= 32'd0;
                                state    <= ST_WRITE_RX;
                            end
                            OPC_READ, OPC_READRES: state <= ST_READ_TX;
                            OPC_ADD, OPC_SUB, OPC_MUL: begin
                                op_a    <= regs[ra];
                                op_b    <= regs[rb];
                                cur_ra  <= ra;
                                fpu_add <= (opc == OPC_ADD);
                                fpu_sub <= (opc == OPC_SUB);
                                fpu_mul <= (opc == OPC_MUL);
                                state   <= ST_OP_START;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_STAT_TX: if (ser_done) state <= ST_IDLE;
                ST_WRITE_RX: begin
                    if (rx_valid) begin
                        shadow   <= (shadow << 8) | BW'(rx_data);
                        to_cnt   <= 32'd0;
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == LAST_BYTE) state <= ST_WRITE_COMMIT;
                    end else if (timeout_evt) begin
                        state <= ST_IDLE;
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                ST_WRITE_COMMIT: begin
                    regs[cur_ra] <= shadow[BW-1 -: W];
                    state        <= ST_IDLE;
                end
                ST_READ_TX: begin
                    if (ser_done)   state <= ST_IDLE;
                    else if (tx_en) state <= ST_TX_GAP;
                end
                ST_TX_GAP:   state <= ST_READ_TX;
                ST_OP_START: state <= ST_OP_GUARD;
                ST_OP_GUARD: state <= ST_OP_WAIT;
                ST_OP_WAIT:  if (fpu_idle) state <= WB_EN ? ST_OP_WB : ST_IDLE;
                ST_OP_WB: begin
`ifdef ZUSE_CTRL_WRITEBACK_EN
                    regs[cur_ra] <= fpu_res;
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zuse_uart_ctrl_n.sv
// tb/tb_zuse_uart_ctrl_n.sv - directed scoreboard bench for zuse_uart_ctrl_n (NREGS=2, TIMEOUT_CYC=100)
module tb_zuse_uart_ctrl_n;

    localparam int W = 23;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         tx_busy = 1'b0;
    logic         tx_en;
    logic [7:0]   tx_data;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         fpu_add;
    logic         fpu_sub;
    logic         fpu_mul;
    logic [W-1:0] fpu_res = '0;
    logic [2:0]   fpu_flags = 3'b000;
    logic         fpu_idle = 1'b1;

    int           vectors = 0;
    int           errors = 0;
    int           busy_cnt = 0;
    int           add_cnt = 0;
    int           sub_cnt = 0;
    int           mul_cnt = 0;
    logic [7:0]   sb [$];
    logic [W-1:0] m_regs [4];

    always #5 clk = ~clk;

    zuse_uart_ctrl_n #(
        .EXP_W(7), .MAN_W(15), .NREGS(2), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
        .op_a(op_a), .op_b(op_b), .fpu_add(fpu_add), .fpu_sub(fpu_sub), .fpu_mul(fpu_mul),
        .fpu_res(fpu_res), .fpu_flags(fpu_flags), .fpu_idle(fpu_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at negedge, score tx bytes, then model the transmitter's busy window.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (fpu_add) add_cnt++;
        if (fpu_sub) sub_cnt++;
        if (fpu_mul) mul_cnt++;
        if (tx_en) begin
            chk("tx_en_while_busy", 32'(tx_busy), 32'd0);
            vectors++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_tx observed=0x%0h expected=no_byte", tx_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("tx_byte", 32'(tx_data), 32'(e));
            end
            busy_cnt = 4;
            tx_busy  = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            tx_busy = (busy_cnt != 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        logic [23:0] v;
        v = {w, 1'b0};
        sb.push_back(v[23:16]);
        sb.push_back(v[15:8]);
        sb.push_back(v[7:0]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || tx_busy) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_remaining", 32'(sb.size()), 32'd0);
        idle(3);
    endtask

    task automatic write_reg(input logic [1:0] idx, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [23:0] t;
        t = {b0, b1, b2};
        send({4'h1, idx, 2'b00});
        send(b0);
        send(b1);
        send(b2);
        m_regs[idx] = t[23:1];
        idle(2);
    endtask

    task automatic read_reg(input logic [1:0] idx);
        push_word(m_regs[idx]);
        send({4'h2, idx, 2'b00});
        drain();
    endtask

    task automatic status(input logic [7:0] exp);
        sb.push_back(exp);
        send(8'h00);
        drain();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        idle(3);
        reset = 1'b0;
        tick();
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_op_a", 32'(op_a), 32'd0);
        chk("rst_op_b", 32'(op_b), 32'd0);
        chk("rst_starts", 32'({fpu_add, fpu_sub, fpu_mul}), 32'd0);
        read_reg(2'd0);
        status(8'h00);

        write_reg(2'd0, 8'h05, 8'h80, 8'h00);
        write_reg(2'd1, 8'h12, 8'h34, 8'h56);
        read_reg(2'd0);
        read_reg(2'd1);

        fpu_res  = 23'h3ABCDE;
        fpu_idle = 1'b0;
        add_cnt  = 0;
        send(8'h41);
        chk("add_start", 32'(fpu_add), 32'd1);
        chk("add_op_a", 32'(op_a), 32'(m_regs[0]));
        chk("add_op_b", 32'(op_b), 32'(m_regs[1]));
        idle(10);
        send(8'h00);
        idle(10);
        chk("add_op_a_held", 32'(op_a), 32'(m_regs[0]));
        chk("add_pulse_count", 32'(add_cnt), 32'd1);
        fpu_idle = 1'b1;
        idle(4);
`ifdef ZUSE_CTRL_WRITEBACK_EN
        m_regs[0] = 23'h3ABCDE;
`endif
        push_word(23'h3ABCDE);
        send(8'h30);
        fpu_res = 23'h000000;
        drain();
        read_reg(2'd0);

        fpu_res = 23'h012345;
        sub_cnt = 0;
        send(8'h55);
        chk("sub_start", 32'(fpu_sub), 32'd1);
        chk("sub_op_a", 32'(op_a), 32'(m_regs[1]));
        chk("sub_op_b", 32'(op_b), 32'(m_regs[1]));
        idle(6);
        chk("sub_pulse_count", 32'(sub_cnt), 32'd1);
`ifdef ZUSE_CTRL_WRITEBACK_EN
        m_regs[1] = 23'h012345;
`endif
        read_reg(2'd1);
        mul_cnt = 0;
        send(8'h64);
        chk("mul_start", 32'(fpu_mul), 32'd1);
        chk("mul_op_a", 32'(op_a), 32'(m_regs[1]));
        chk("mul_op_b", 32'(op_b), 32'(m_regs[0]));
        idle(6);
        chk("mul_pulse_count", 32'(mul_cnt), 32'd1);
`ifdef ZUSE_CTRL_WRITEBACK_EN
        m_regs[1] = 23'h012345;
`endif

        send(8'h2C);
        idle(8);
        status(8'h80);
        status(8'h00);
        send(8'h42);
        chk("bad_add_no_start", 32'(fpu_add), 32'd0);
        idle(3);
        status(8'h80);
        send(8'h70);
        idle(2);
        status(8'h80);
        push_word(m_regs[0]);
        send(8'h23);
        drain();
        fpu_idle  = 1'b0;
        fpu_flags = 3'b101;
        status(8'h0D);
        fpu_idle  = 1'b1;
        fpu_flags = 3'b000;

        send(8'h12);
        send(8'hAA);
        idle(95);
        send(8'hBB);
        send(8'hCC);
        m_regs[0] = 23'h555DE6;
        idle(2);
        read_reg(2'd0);
        status(8'h00);
        send(8'h12);
        send(8'hAA);
        idle(105);
        status(8'h40);
        read_reg(2'd0);

        write_reg(2'd1, 8'hC3, 8'h3C, 8'h81);
        push_word(m_regs[1]);
        send(8'h24);
        send(8'h20);
        send(8'h11);
        send(8'h00);
        drain();

        send(8'h11);
        send(8'h12);
        send(8'h34);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        chk("midrst_tx_en", 32'(tx_en), 32'd0);
        chk("midrst_op_a", 32'(op_a), 32'd0);
        tick();
        read_reg(2'd0);
        read_reg(2'd1);
        status(8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
